// File: rtl/mac_sequencer_if.sv
// Job, operand-stream, result-stream and datapath-control signals of the MAC sequencer.
// master is the sequencer's view; slave is the stream source/sink and datapath side.
interface mac_sequencer_if #(
    parameter int TERMS_W = 4
);
    logic               start;
    logic [TERMS_W-1:0] n_terms;
    logic               abort;
    logic               in_valid;
    logic               in_bit;
    logic               in_ready;
    logic               out_valid;
    logic               out_bit;
    logic               out_ready;
    logic               busy;
    logic               done;
    logic [1:0]         mac_cmd;
    logic               mac_step;
    logic               mac_d_in;
    logic               mac_d_out;

    modport master (
        input  start, n_terms, abort, in_valid, in_bit, out_ready, mac_d_out,
        output in_ready, out_valid, out_bit, busy, done, mac_cmd, mac_step, mac_d_in
    );

    modport slave (
        output start, n_terms, abort, in_valid, in_bit, out_ready, mac_d_out,
        input  in_ready, out_valid, out_bit, busy, done, mac_cmd, mac_step, mac_d_in
    );
endinterface

// File: rtl/mac_sequencer.sv
// Sequences a serial MAC datapath: clear, shift 2*WIDTH operand bits per term, accumulate, drain result.
// First result bit 2 + n_terms*(2*WIDTH+1) cycles after start; stalled streams freeze the datapath via mac_step.
module mac_sequencer #(
    parameter int WIDTH   = 3,
    parameter int TERMS_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    mac_sequencer_if.master bus
);
    localparam int NBITS = 2 * WIDTH;
    localparam int CNT_W = $clog2(NBITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

    localparam logic [1:0] CMD_CLR      = 2'b00;
    localparam logic [1:0] CMD_SHIFT_AB = 2'b01;
    localparam logic [1:0] CMD_ACC      = 2'b10;
    localparam logic [1:0] CMD_SHIFT_C  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_ACC,
        S_DRAIN,
        S_ABORT
    } state_t;

    state_t             r_state;
    logic [1:0]         r_cmd;
    logic               r_done;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [TERMS_W-1:0] r_term_cnt;

    logic w_in_hs;
    logic w_out_hs;
    logic w_step;

    // abort suppresses the handshake so the offered bit is never shifted in
    assign w_in_hs  = (r_state == S_LOAD)  && bus.in_valid  && !bus.abort;
    assign w_out_hs = (r_state == S_DRAIN) && bus.out_ready && !bus.abort;

    always_comb begin
        w_step = 1'b0;
        case (r_state)
            S_CLR, S_ACC, S_ABORT: w_step = 1'b1;
            S_LOAD:                w_step = w_in_hs;
            S_DRAIN:               w_step = w_out_hs;
            default:               w_step = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cmd      <= CMD_CLR;
            r_done     <= 1'b0;
            r_bit_cnt  <= '0;
            r_term_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE && bus.abort) begin
                r_state    <= S_ABORT;
                r_cmd      <= CMD_CLR;
                r_bit_cnt  <= '0;
                r_term_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_term_cnt <= bus.n_terms;
                            r_bit_cnt  <= '0;
                            r_state    <= S_CLR;
                            r_cmd      <= CMD_CLR;
                        end
                    end
                    S_CLR: begin
                        if (r_term_cnt != '0) begin
                            r_state <= S_LOAD;
                            r_cmd   <= CMD_SHIFT_AB;
                        end else begin
                            r_state <= S_DRAIN;
                            r_cmd   <= CMD_SHIFT_C;
                        end
                    end
                    S_LOAD: begin
                        if (w_in_hs) begin
                            if (r_bit_cnt == LAST_BIT) begin
                                r_bit_cnt <= '0;
                                r_state   <= S_ACC;
                                r_cmd     <= CMD_ACC;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_ACC: begin
                        r_term_cnt <= r_term_cnt - TERMS_W'(1);
                        if (r_term_cnt != TERMS_W'(1)) begin
                            r_state <= S_LOAD;
                            r_cmd   <= CMD_SHIFT_AB;
                        end else begin
                            r_state <= S_DRAIN;
                            r_cmd   <= CMD_SHIFT_C;
                        end
                    end
                    S_DRAIN: begin
                        if (w_out_hs) begin
                            if (r_bit_cnt == LAST_BIT) begin
                                r_bit_cnt <= '0;
                                r_state   <= S_IDLE;
                                r_cmd     <= CMD_CLR;
                                r_done    <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_ABORT: begin
                        r_state <= S_IDLE;
                        r_cmd   <= CMD_CLR;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cmd   <= CMD_CLR;
                    end
                endcase
            end
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.in_ready  = (r_state == S_LOAD);
    assign bus.out_valid = (r_state == S_DRAIN);
    assign bus.done      = r_done;
    assign bus.mac_cmd   = r_cmd;
    assign bus.mac_step  = w_step;
    assign bus.mac_d_in  = bus.in_bit;
    assign bus.out_bit   = bus.mac_d_out;
endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer with a behavioural serial MAC datapath and a result-bit scoreboard.
module tb_mac_sequencer;
    localparam int WIDTH   = 3;
    localparam int TERMS_W = 4;
    localparam int NB      = 2 * WIDTH;

    logic clk = 1'b0;
    logic reset;
    int   vec    = 0;
    int   miscmp = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    mac_sequencer_if #(.TERMS_W(TERMS_W)) bus();

    mac_sequencer #(.WIDTH(WIDTH), .TERMS_W(TERMS_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Datapath: {b,a} is one SIPO chain, so the first bit shifted in ends up as b's MSB.
    logic [WIDTH-1:0]   dp_a, dp_b;
    logic [2*WIDTH-1:0] dp_acc;
    always @(posedge clk) begin
        if (bus.mac_step === 1'b1) begin
            case (bus.mac_cmd)
                2'b00:   begin dp_a <= '0; dp_b <= '0; dp_acc <= '0; end
                2'b01:   {dp_b, dp_a} <= {dp_b[WIDTH-2:0], dp_a, bus.mac_d_in};
                2'b10:   dp_acc <= dp_acc + dp_a * dp_b;
                default: dp_acc <= dp_acc << 1;
            endcase
        end
    end
    assign bus.mac_d_out = dp_acc[2*WIDTH-1];

    task automatic run_job(input string name, input int nt,
                           input logic [3:0][2:0] av, input logic [3:0][2:0] bv,
                           input int stall_pct, input int abort_c, input int restart_c,
                           input int exp_first_ov, input int exp_acc, input logic [5:0] exp_res);
        logic stream[$];
        logic [5:0] sum = '0;
        logic [5:0] got = '0;
        logic e;
        int idx = 0, c = 0, acc_n = 0, done_n = 0, ir_n = 0, first_ov = -1, done_c = -1;
        bit aborted = (abort_c >= 0);
        for (int t = 0; t < nt; t++) begin
            for (int i = WIDTH - 1; i >= 0; i--) stream.push_back(bv[t][i]);
            for (int i = WIDTH - 1; i >= 0; i--) stream.push_back(av[t][i]);
            sum = sum + 6'(av[t]) * 6'(bv[t]);
        end
        if (!aborted) for (int i = NB - 1; i >= 0; i--) exp_q.push_back(sum[i]);

        @(negedge clk);
        bus.start = 1'b1; bus.n_terms = TERMS_W'(nt); bus.abort = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        while (c < 400) begin
            @(negedge clk);
            c++;
            bus.start = (c == restart_c);
            if (c == restart_c) bus.n_terms = 4'd5;
            bus.abort     = (c == abort_c);
            bus.in_valid  = (idx < stream.size()) && (int'($urandom_range(99)) >= stall_pct);
            bus.in_bit    = (idx < stream.size()) ? stream[idx] : 1'b0;
            bus.out_ready = (int'($urandom_range(99)) >= stall_pct);
            #1;
            if (bus.in_ready) ir_n++;
            if ((bus.in_ready && !bus.in_valid) || (bus.out_valid && !bus.out_ready)) begin
                vec++;
                if (bus.mac_step !== 1'b0) begin
                    miscmp++;
                    $display("FAIL %s stall_step c=%0d: got %b expected 0", name, c, bus.mac_step);
                end
            end
            if (bus.in_ready && bus.in_valid && !bus.abort) idx++;
            if (bus.mac_cmd == 2'b10 && bus.mac_step) acc_n++;
            if (bus.out_valid && first_ov < 0) first_ov = c;
            if (bus.out_valid && bus.out_ready && !bus.abort) begin
                got = {got[4:0], bus.out_bit};
                vec++;
                if (exp_q.size() == 0) begin
                    miscmp++;
                    $display("FAIL %s out_bit c=%0d: got %b expected no output", name, c, bus.out_bit);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_bit !== e) begin
                        miscmp++;
                        $display("FAIL %s out_bit c=%0d: got %b expected %b", name, c, bus.out_bit, e);
                    end
                end
            end
            if (bus.done) begin done_n++; done_c = c; end
            if (aborted && c == abort_c + 1) begin
                vec++;
                if ({bus.mac_cmd, bus.mac_step, bus.busy} !== 4'b0011) begin
                    miscmp++;
                    $display("FAIL %s abort_clr: got %b expected 0011", name, {bus.mac_cmd, bus.mac_step, bus.busy});
                end
            end
            if (aborted && c == abort_c + 2) begin
                vec++;
                if ({bus.busy, bus.done} !== 2'b00) begin
                    miscmp++;
                    $display("FAIL %s abort_idle: got %b expected 00", name, {bus.busy, bus.done});
                end
                break;
            end
            if (bus.done) break;
        end
        bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;

        vec++;
        if (c >= 400) begin
            miscmp++;
            $display("FAIL %s timeout: got %0d cycles expected < 400", name, c);
        end
        vec++;
        if (exp_q.size() != 0) begin
            miscmp++;
            $display("FAIL %s leftover: got %0d pending bits expected 0", name, exp_q.size());
            exp_q.delete();
        end
        vec++;
        if (done_n != (aborted ? 0 : 1)) begin
            miscmp++;
            $display("FAIL %s done_count: got %0d expected %0d", name, done_n, aborted ? 0 : 1);
        end
        vec++;
        if (acc_n != exp_acc) begin
            miscmp++;
            $display("FAIL %s acc_count: got %0d expected %0d", name, acc_n, exp_acc);
        end
        if (!aborted) begin
            vec++;
            if (got !== exp_res) begin
                miscmp++;
                $display("FAIL %s result: got %0d expected %0d", name, got, exp_res);
            end
        end
        if (exp_first_ov >= 0) begin
            vec++;
            if (first_ov != exp_first_ov) begin
                miscmp++;
                $display("FAIL %s first_out_valid: got %0d expected %0d", name, first_ov, exp_first_ov);
            end
            vec++;
            if (done_c != exp_first_ov + NB) begin
                miscmp++;
                $display("FAIL %s done_cycle: got %0d expected %0d", name, done_c, exp_first_ov + NB);
            end
        end
        if (nt == 0) begin
            vec++;
            if (ir_n != 0) begin
                miscmp++;
                $display("FAIL %s in_ready_cycles: got %0d expected 0", name, ir_n);
            end
        end
        @(negedge clk);
        #1;
        vec++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            miscmp++;
            $display("FAIL %s after_job: got %b expected 00", name, {bus.busy, bus.done});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.n_terms = '0; bus.abort = 1'b0;
        bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.out_ready = 1'b0;
        #1;
        vec++;
        if ({bus.busy, bus.in_ready, bus.out_valid, bus.done, bus.mac_step, bus.mac_cmd} !== 7'b0) begin
            miscmp++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {bus.busy, bus.in_ready, bus.out_valid, bus.done, bus.mac_step, bus.mac_cmd});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        #1;
        vec++;
        if ({bus.busy, bus.mac_step, bus.mac_cmd} !== 4'b0) begin
            miscmp++;
            $display("FAIL idle_abort: got %b expected 0000", {bus.busy, bus.mac_step, bus.mac_cmd});
        end
    endtask

    task automatic test_single();
        run_job("single", 1, {3'd0, 3'd0, 3'd0, 3'd3}, {3'd0, 3'd0, 3'd0, 3'd5}, 0, -1, 4, 9, 1, 6'd15);
    endtask

    task automatic test_two_terms();
        run_job("two_terms", 2, {3'd0, 3'd0, 3'd7, 3'd7}, {3'd0, 3'd0, 3'd7, 3'd7}, 0, -1, -1, 16, 2, 6'd34);
    endtask

    task automatic test_zero_terms();
        run_job("zero_terms", 0, '0, '0, 0, -1, -1, 2, 0, 6'd0);
    endtask

    task automatic test_stalls();
        for (int k = 0; k < 3; k++)
            run_job("stalls", 1, {3'd0, 3'd0, 3'd0, 3'd3}, {3'd0, 3'd0, 3'd0, 3'd5}, 40, -1, -1, -1, 1, 6'd15);
    endtask

    task automatic test_abort();
        run_job("abort", 1, {3'd0, 3'd0, 3'd0, 3'd3}, {3'd0, 3'd0, 3'd0, 3'd5}, 0, 5, -1, -1, 0, 6'd0);
        run_job("after_abort", 1, {3'd0, 3'd0, 3'd0, 3'd2}, {3'd0, 3'd0, 3'd0, 3'd3}, 0, -1, -1, 9, 1, 6'd6);
    endtask

    task automatic test_reset_drain();
        int n = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.n_terms = 4'd0;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        vec++;
        if (bus.out_valid !== 1'b1) begin
            miscmp++;
            $display("FAIL reset_drain_reach: got %b expected 1", bus.out_valid);
        end
        bus.out_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        vec++;
        if ({bus.busy, bus.in_ready, bus.out_valid, bus.done, bus.mac_step, bus.mac_cmd} !== 7'b0) begin
            miscmp++;
            $display("FAIL reset_drain_outputs: got %b expected 0000000",
                     {bus.busy, bus.in_ready, bus.out_valid, bus.done, bus.mac_step, bus.mac_cmd});
        end
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        #1;
        vec++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            miscmp++;
            $display("FAIL reset_drain_idle: got %b expected 00", {bus.busy, bus.done});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_terms();
        test_zero_terms();
        test_stalls();
        test_abort();
        test_reset_drain();
        run_job("post_reset", 1, {3'd0, 3'd0, 3'd0, 3'd3}, {3'd0, 3'd0, 3'd0, 3'd5}, 0, -1, -1, 9, 1, 6'd15);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
